// File: rtl/dmem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : dmem_bridge
// Brief    : Memory-stage load/store bridge onto a doubleword valid/ready bus
//            with byte strobes. Optional response timeout: DMEM_BRIDGE_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module dmem_bridge #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [3:0]  req_wlen,
    output logic        req_stall,
    output logic        resp_done,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        bus_avalid,
    input  logic        bus_aready,
    output logic        bus_awrite,
    output logic [63:0] bus_addr,
    output logic [63:0] bus_wdata,
    output logic [7:0]  bus_wstrb,
    output logic        bus_rready,
    input  logic        bus_rvalid,
    input  logic [63:0] bus_rdata,
    input  logic        bus_rerr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    logic [2:0]  r_off;
    logic [3:0]  r_wlen;
    logic        r_wen;

    logic [7:0]  w_req_lanes;
    logic        w_legal;
    logic [7:0]  w_resp_lanes;
    logic [63:0] w_resp_mask;
    logic [63:0] w_rdata_aligned;
    logic        w_timeout;

    if (TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("dmem_bridge: TIMEOUT_CYCLES must be at least 1");
    end

    // Unsupported sizes map to an empty lane set, which doubles as the legality test.
    function automatic logic [7:0] lane_mask(input logic [3:0] len);
        case (len)
            4'd1:    lane_mask = 8'h01;
            4'd2:    lane_mask = 8'h03;
            4'd4:    lane_mask = 8'h0F;
            4'd8:    lane_mask = 8'hFF;
            default: lane_mask = 8'h00;
        endcase
    endfunction

    assign w_req_lanes = lane_mask(req_wlen);
    assign w_legal     = (w_req_lanes != 8'h00) &&
                         ((req_addr[2:0] & (req_wlen[2:0] - 3'd1)) == 3'd0);

    assign w_resp_lanes    = lane_mask(r_wlen);
    assign w_rdata_aligned = bus_rdata >> {r_off, 3'b000};

    always_comb begin
        w_resp_mask = '0;
        for (int i = 0; i < 8; i++) begin
            w_resp_mask[i*8 +: 8] = {8{w_resp_lanes[i]}};
        end
    end

    assign req_stall = req_valid & (state != DONE);

`ifdef DMEM_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (state == IDLE) begin
            r_cnt <= '0;
        end else if (state == ADDR || state == RESP) begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    // Fires in the cycle whose increment would land on the limit.
    assign w_timeout = ((state == ADDR) || (state == RESP)) && ((r_cnt + CNT_ONE) == TIMEOUT_VAL);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            r_off      <= '0;
            r_wlen     <= '0;
            r_wen      <= 1'b0;
            resp_done  <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            bus_avalid <= 1'b0;
            bus_awrite <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_wstrb  <= '0;
            bus_rready <= 1'b0;
        end else begin
            resp_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (w_legal) begin
                            r_off      <= req_addr[2:0];
                            r_wlen     <= req_wlen;
                            r_wen      <= req_wen;
                            bus_addr   <= {req_addr[63:3], 3'b000};
                            bus_wdata  <= req_wdata << {req_addr[2:0], 3'b000};
                            bus_wstrb  <= req_wen ? (w_req_lanes << req_addr[2:0]) : 8'h00;
                            bus_awrite <= req_wen;
                            bus_avalid <= 1'b1;
                            state      <= ADDR;
                        end else begin
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            resp_done  <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                ADDR: begin
                    if (bus_aready) begin
                        bus_avalid <= 1'b0;
                        bus_rready <= 1'b1;
                        state      <= RESP;
                    end else if (w_timeout) begin
                        bus_avalid <= 1'b0;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                        resp_done  <= 1'b1;
                        state      <= DONE;
                    end
                end
                RESP: begin
                    if (bus_rvalid) begin
                        bus_rready <= 1'b0;
                        resp_err   <= bus_rerr;
                        resp_rdata <= (!r_wen && !bus_rerr) ? (w_rdata_aligned & w_resp_mask) : '0;
                        resp_done  <= 1'b1;
                        state      <= DONE;
                    end else if (w_timeout) begin
                        bus_rready <= 1'b0;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                        resp_done  <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Data-memory bridge directly downstream of the pipeline's memory stage.
- Accepts one load/store request (address, write data, byte length, write enable) at a time and stalls the pipeline while the request is outstanding.
- Converts the request into a doubleword-aligned valid/ready transaction on a simple data bus with byte strobes, then returns lane-aligned, zero-extended read data with a one-cycle done pulse.

Parameters:
- TIMEOUT_CYCLES, 255: response wait limit in cycles; used only when DMEM_BRIDGE_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present; held stable by upstream while req_stall=1
- req_wen  in  1  1=store, 0=load
- req_addr  in  64  byte address
- req_wdata  in  64  store data, LSB-aligned
- req_wlen  in  4  access size in bytes: 1, 2, 4 or 8
- req_stall  out  1  pipeline stall
- resp_done  out  1  one-cycle completion pulse
- resp_rdata  out  64  load data, shifted to bit 0 and zero-extended
- resp_err  out  1  error status for the completed access
- bus_avalid  out  1  address/data request valid
- bus_aready  in  1  slave accepts the request
- bus_awrite  out  1  request is a write
- bus_addr  out  64  {req_addr[63:3], 3'b000}
- bus_wdata  out  64  req_wdata shifted left by addr[2:0]*8
- bus_wstrb  out  8  byte enables: ((1<<wlen)-1) << addr[2:0]; zero for reads
- bus_rready  out  1  ready for response
- bus_rvalid  in  1  response valid; returned for both reads and writes
- bus_rdata  in  64  read doubleword, ignored for writes
- bus_rerr  in  1  slave error on this response

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- States: IDLE, ADDR, RESP, DONE.
- Reset values: state=IDLE; all bus_* outputs=0; resp_done=0; resp_rdata=0; resp_err=0.
- Reset asserted mid-transaction abandons the transaction immediately, with no completion pulse.
- req_stall = req_valid & (state != DONE). This is combinational, so a new request stalls in the same cycle it appears.
- IDLE, req_valid=1, access legal:
  - Capture addr, wdata, wlen and wen into internal registers.
  - Go to ADDR.
- IDLE, req_valid=1, access illegal:
  - Illegal means wlen not in {1,2,4,8}, or addr[2:0] not a multiple of wlen.
  - Go to DONE with resp_err=1 and resp_rdata=0. No bus activity.
- ADDR:
  - bus_avalid=1, and bus_addr/bus_wdata/bus_wstrb/bus_awrite are driven from the captured registers.
  - Payload stays stable until bus_aready=1.
  - On avalid & aready, go to RESP.
- RESP:
  - bus_rready=1.
  - On bus_rvalid=1, latch resp_err=bus_rerr.
  - For loads with no error, latch resp_rdata = (bus_rdata >> addr[2:0]*8) masked to wlen bytes. Otherwise resp_rdata=0.
  - Go to DONE.
- DONE:
  - resp_done=1 for exactly one cycle, and req_stall=0.
  - Always return to IDLE on the next cycle. A request present in DONE is not accepted until IDLE.
- resp_rdata and resp_err hold their values until the next DONE.
- Minimum latency from IDLE acceptance to resp_done: 3 cycles (capture, ADDR with immediate aready, RESP with immediate rvalid).
- Error path latency: 1 cycle.
- Sign extension of load data is not done here; the memory stage performs it using funct3.
- Only one transaction is ever outstanding.
- bus_rvalid seen outside RESP is ignored.
- bus_aready seen outside ADDR is ignored.

Optional Feature:
- Macro: DMEM_BRIDGE_TIMEOUT_EN.
- Defined:
  - An 8-bit or wider counter clears on entry to ADDR and increments each cycle spent in ADDR or RESP.
  - When the counter reaches TIMEOUT_CYCLES, go to DONE with resp_err=1 and resp_rdata=0. bus_avalid and bus_rready drop that cycle.
- Not defined: no counter exists, and the bridge waits indefinitely in ADDR/RESP.

Test Plan:
- Load, aligned 8B: addr=0x80000010, wlen=8, aready and rvalid immediate, rdata=0x1122334455667788 -> bus_wstrb=0x00; resp_done 3 cycles after acceptance; resp_rdata=0x1122334455667788; resp_err=0.
- Load, sub-word: addr=0x80000006, wlen=2, rdata=0xAABBCCDD11223344 -> bus_addr=0x80000000; resp_rdata=0x000000000000AABB.
- Store, sub-word: addr=0x80000004, wlen=4, wdata=0xDEADBEEF -> bus_wstrb=0xF0, bus_wdata=0xDEADBEEF00000000, bus_awrite=1; resp_done after rvalid; req_stall low only in the DONE cycle.
- Misaligned access: addr=0x80000003, wlen=4 -> no bus_avalid; resp_done the next cycle with resp_err=1.
- Backpressure and reset: aready held low 5 cycles -> payload stable and req_stall=1 throughout. A second run asserts rst while in RESP -> all outputs 0 immediately, state IDLE, no resp_done.
- Timeout (macro defined, TIMEOUT_CYCLES=4): rvalid never asserted -> resp_err=1 and resp_done 4 cycles after entering ADDR. Macro undefined: req_stall stays high for 100 cycles.
